// File: rtl/fp_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fp_pkg : shared widths, constants and FSM state type for fp_normalize_round |
// | Revision: 1.0                                                               |
// +---------------------------------------------------------------------------+
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fp_round_rne.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fp_round_rne : round-to-nearest-even increment with carry / subnormal fix   |
// | Revision: 1.0                                                               |
// +---------------------------------------------------------------------------+
module fp_round_rne #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W
) (
  input  logic [MAN_W:0]   sig_in,
  input  logic             guard,
  input  logic             rnd,
  input  logic             sticky,
  input  logic [EXP_W:0]   exp_in,
  output logic [MAN_W-1:0] frac_out,
  output logic [EXP_W:0]   exp_out
);
  import fp_pkg::*;

  localparam logic [EXP_W:0] c_one = {{EXP_W{1'b0}}, 1'b1};

  logic             w_inc;
  logic [MAN_W+1:0] w_sum;

  assign w_inc = guard & (rnd | sticky | sig_in[0]);
  assign w_sum = {1'b0, sig_in} + {{(MAN_W + 1){1'b0}}, w_inc};

  always_comb begin
    frac_out = w_sum[MAN_W-1:0];
    exp_out  = exp_in;
    if (w_sum[MAN_W+1]) begin
      frac_out = w_sum[MAN_W:1];
      exp_out  = exp_in + c_one;
    end else if ((exp_in == '0) && w_sum[MAN_W]) begin
      // a subnormal that rounds into the hidden bit becomes the smallest normal
      exp_out  = c_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_normalize_round.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fp_normalize_round : normalizes an adder sum one bit per cycle, rounds RNE  |
// | Revision: 1.0                                                               |
// +---------------------------------------------------------------------------+
module fp_normalize_round #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [MAN_W+4:0]       in_mant,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic                   out_overflow,
  output logic                   out_underflow,
  output logic                   out_zero
);
  import fp_pkg::*;

  localparam int             MW         = MAN_W + 5;
  localparam logic [EXP_W:0] c_one      = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] c_exp_ones = {1'b0, {EXP_W{1'b1}}};

  state_t               r_state, w_state_nxt;
  logic                 r_sign, w_sign_nxt;
  logic [EXP_W:0]       r_exp, w_exp_nxt;
  logic [MW-1:0]        r_mant, w_mant_nxt;
  logic [EXP_W+MAN_W:0] r_result, w_result_nxt;
  logic                 r_ovf, w_ovf_nxt;
  logic                 r_unf, w_unf_nxt;
  logic                 r_zero, w_zero_nxt;
  logic [MAN_W-1:0]     w_frac_rnd;
  logic [EXP_W:0]       w_exp_rnd;

  fp_round_rne #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .sig_in   (r_mant[MW-2:3]),
    .guard    (r_mant[2]),
    .rnd      (r_mant[1]),
    .sticky   (r_mant[0]),
    .exp_in   (r_exp),
    .frac_out (w_frac_rnd),
    .exp_out  (w_exp_rnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sign_nxt   = r_sign;
    w_exp_nxt    = r_exp;
    w_mant_nxt   = r_mant;
    w_result_nxt = r_result;
    w_ovf_nxt    = r_ovf;
    w_unf_nxt    = r_unf;
    w_zero_nxt   = r_zero;
    case (r_state)
      IDLE: begin
        if (in_valid && in_ready) begin
          w_sign_nxt = in_sign;
          w_exp_nxt  = {1'b0, in_exp};
          w_mant_nxt = in_mant;
          if (in_mant == '0) begin
            w_result_nxt = {in_sign, {(EXP_W + MAN_W){1'b0}}};
            w_ovf_nxt    = 1'b0;
            w_unf_nxt    = 1'b0;
            w_zero_nxt   = 1'b1;
            w_state_nxt  = DONE;
          end else if (in_exp == '1) begin
            w_result_nxt = {in_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_ovf_nxt    = 1'b1;
            w_unf_nxt    = 1'b0;
            w_zero_nxt   = 1'b0;
            w_state_nxt  = DONE;
          end else begin
            w_state_nxt  = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (r_mant[MW-1]) begin
          // the bit dropped off the bottom folds into sticky
          w_mant_nxt  = {1'b0, r_mant[MW-1:2], r_mant[1] | r_mant[0]};
          w_exp_nxt   = r_exp + c_one;
          w_state_nxt = ROUND;
        end else if (r_mant[MW-2]) begin
          w_state_nxt = ROUND;
        end else if (r_exp > c_one) begin
          w_mant_nxt  = {r_mant[MW-2:0], 1'b0};
          w_exp_nxt   = r_exp - c_one;
        end else begin
          w_exp_nxt   = '0;
          w_state_nxt = ROUND;
        end
      end
      ROUND: begin
        if (w_exp_rnd >= c_exp_ones) begin
          w_result_nxt = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          w_ovf_nxt    = 1'b1;
          w_unf_nxt    = 1'b0;
          w_zero_nxt   = 1'b0;
        end else begin
          w_result_nxt = {r_sign, w_exp_rnd[EXP_W-1:0], w_frac_rnd};
          w_ovf_nxt    = 1'b0;
          w_unf_nxt    = (w_exp_rnd == '0) && (w_frac_rnd != '0);
          w_zero_nxt   = (w_exp_rnd == '0) && (w_frac_rnd == '0);
        end
        w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_mant   <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_sign   <= w_sign_nxt;
      r_exp    <= w_exp_nxt;
      r_mant   <= w_mant_nxt;
      r_result <= w_result_nxt;
      r_ovf    <= w_ovf_nxt;
      r_unf    <= w_unf_nxt;
      r_zero   <= w_zero_nxt;
    end
  end

  assign in_ready      = (r_state == IDLE);
  assign out_valid     = (r_state == DONE);
  assign out_result    = r_result;
  assign out_overflow  = r_ovf;
  assign out_underflow = r_unf;
  assign out_zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_fp_normalize_round.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_fp_normalize_round : scoreboard bench with value-level RNE reference     |
// | Revision: 1.0                                                               |
// +---------------------------------------------------------------------------+
module tb_fp_normalize_round;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  fl;   // {overflow, underflow, zero}
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic [31:0] res;
    logic [2:0]  fl;
    int          lat;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_zero;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  exp_t exp_q[$];

  fp_normalize_round #(
    .EXP_W (8),
    .MAN_W (23)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_zero      (out_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Exact value = m * 2^(e-153); round that value to single precision with RNE.
  function automatic exp_t model(input logic s, input logic [7:0] e, input logic [27:0] m);
    exp_t   r;
    longint q, rem, half;
    int     p, ee, sh, n, field;
    r.res = '0; r.fl = 3'b000; r.lat = 3; r.acc = 0;
    if (m == 0) begin
      r.res = {s, 31'b0}; r.fl = 3'b001; r.lat = 1;
      return r;
    end
    if (e == 8'hFF) begin
      r.res = {s, 8'hFF, 23'b0}; r.fl = 3'b100; r.lat = 1;
      return r;
    end
    p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    n = 0;
    if (p < 26) n = ((26 - p) < (int'(e) - 1)) ? (26 - p) : (int'(e) - 1);
    r.lat = 3 + n;
    ee = int'(e) + p - 26;
    if (ee < 1) ee = 1;
    sh = int'(e) - ee - 3;
    if (sh >= 0) begin
      q = longint'(m) << sh;
    end else begin
      q    = longint'(m) >> (-sh);
      rem  = longint'(m) - (q << (-sh));
      half = 64'sd1 << (-sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
    end
    if (q >= (64'sd1 << 24)) begin
      q = q >> 1;
      ee++;
    end
    field = (q >= (64'sd1 << 23)) ? ee : 0;
    if (field >= 255) begin
      r.res = {s, 8'hFF, 23'b0}; r.fl = 3'b100;
    end else begin
      r.res = {s, 8'(field), q[22:0]};
      r.fl  = {1'b0, (field == 0) && (q[22:0] != 0), (field == 0) && (q[22:0] == 0)};
    end
    return r;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // monitor: pops on first sight of a result, then watches it hold until taken
  initial begin
    exp_t cur;
    bit   seen;
    seen = 1'b0;
    cur  = '{res: '0, fl: '0, lat: 0, acc: 0};
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (!seen) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL spurious_output: got 0x%0h with no operation outstanding", out_result);
          end else begin
            cur = exp_q.pop_front();
            chk("result", out_result, cur.res);
            chk("flags", 32'({out_overflow, out_underflow, out_zero}), 32'(cur.fl));
            chk("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
            seen = 1'b1;
          end
        end else begin
          chk("hold_result", out_result, cur.res);
          chk("hold_flags", 32'({out_overflow, out_underflow, out_zero}), 32'(cur.fl));
          chk("in_ready_in_done", 32'(in_ready), 32'd0);
        end
        if (out_ready) seen = 1'b0;
      end
    end
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m,
                      input bit track, input exp_t x);
    int   n;
    exp_t y;
    @(negedge clk);
    in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
      in_valid = 1'b0;
      return;
    end
    if (track) begin
      y = x;
      y.acc = cyc + 1;
      exp_q.push_back(y);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(input logic lvl, input string name);
    int n;
    n = 0;
    while (out_valid !== lvl && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(out_valid), 32'(lvl));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    vec_t  vecs[9];
    exp_t  x;
    logic  s;
    logic [7:0]  e;
    logic [27:0] m;
    int    cat;

    vecs[0] = '{s: 1'b0, e: 8'h7F, m: 28'h4000000, res: 32'h3F800000, fl: 3'b000, lat: 3};
    vecs[1] = '{s: 1'b0, e: 8'h7F, m: 28'h8000000, res: 32'h40000000, fl: 3'b000, lat: 3};
    vecs[2] = '{s: 1'b0, e: 8'h7F, m: 28'h0000008, res: 32'h34000000, fl: 3'b000, lat: 26};
    vecs[3] = '{s: 1'b0, e: 8'h7F, m: 28'h400000C, res: 32'h3F800002, fl: 3'b000, lat: 3};
    vecs[4] = '{s: 1'b0, e: 8'h7F, m: 28'h4000014, res: 32'h3F800002, fl: 3'b000, lat: 3};
    vecs[5] = '{s: 1'b0, e: 8'hFE, m: 28'h7FFFFFC, res: 32'h7F800000, fl: 3'b100, lat: 3};
    vecs[6] = '{s: 1'b0, e: 8'h01, m: 28'h0000008, res: 32'h00000001, fl: 3'b010, lat: 3};
    vecs[7] = '{s: 1'b1, e: 8'h55, m: 28'h0000000, res: 32'h80000000, fl: 3'b001, lat: 1};
    vecs[8] = '{s: 1'b1, e: 8'hFF, m: 28'h4000000, res: 32'hFF800000, fl: 3'b100, lat: 1};

    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_result", out_result, 32'd0);
    chk("reset_flags", 32'({out_overflow, out_underflow, out_zero}), 32'd0);

    foreach (vecs[i]) begin
      x = '{res: vecs[i].res, fl: vecs[i].fl, lat: vecs[i].lat, acc: 0};
      send(vecs[i].s, vecs[i].e, vecs[i].m, 1'b1, x);
    end

    // held result under backpressure
    wait_valid(1'b0, "drain_before_stall");
    ready_mode = 2;
    x = '{res: 32'h3F800000, fl: 3'b000, lat: 3, acc: 0};
    send(1'b0, 8'h7F, 28'h4000000, 1'b1, x);
    wait_valid(1'b1, "stall_valid");
    repeat (5) @(negedge clk);
    chk("stall_still_valid", 32'(out_valid), 32'd1);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    ready_mode = 0;
    wait_valid(1'b0, "release_drain");
    chk("release_in_ready", 32'(in_ready), 32'd1);

    // reset in the middle of a long normalization
    x = '{res: '0, fl: '0, lat: 0, acc: 0};
    send(1'b0, 8'h7F, 28'h0000001, 1'b0, x);
    repeat (4) @(negedge clk);
    chk("mid_shift_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_in_ready", 32'(in_ready), 32'd1);
    chk("async_reset_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_out_valid", 32'(out_valid), 32'd0);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    chk("post_reset_out_result", out_result, 32'd0);
    repeat (40) @(negedge clk);

    // randomized traffic with random backpressure
    ready_mode = 1;
    for (int k = 0; k < 200; k++) begin
      cat = $urandom_range(0, 9);
      s = 1'($urandom);
      e = 8'($urandom_range(1, 254));
      m = 28'($urandom);
      case (cat)
        0: m = '0;
        1: begin e = 8'hFF; m[26] = 1'b1; end
        2, 3: m[27] = 1'b1;
        4, 5: m[27:26] = 2'b01;
        6, 7: begin m[27:26] = 2'b01; m = m >> $urandom_range(1, 26); end
        8: begin e = 8'($urandom_range(1, 4)); m[27:26] = 2'b01; m = m >> $urandom_range(1, 26); end
        default: begin
          e = 8'($urandom_range(253, 254));
          m[26:3] = 24'hFFFFFF;
          m[27] = ($urandom_range(0, 3) == 0);
        end
      endcase
      send(s, e, m, 1'b1, model(s, e, m));
    end

    ready_mode = 0;
    for (int n = 0; n < 2000 && exp_q.size() != 0; n++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
